insn_loader: RTL
================

# insn_loader

Boot-time writer for the instruction memory. It takes a byte stream from the host link and packs it little-endian into LEN_INSN-bit words. It writes those words sequentially into the instruction memory write port, then raises `run_o`, which drives the fetcher's `valid_i` to start execution. It is the write side of the same instruction memory that the fetcher reads.

## Interface
Parameters:
- `LEN_INSN`, 32, instruction width in bits; must be a multiple of 8.
- `MEM_INSN_ADDR`, 10, instruction memory address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- `count_i`  in  MEM_INSN_ADDR+1  number of instructions to load, sampled with `start_i`.
- `byte_valid_i`  in  1  byte present on `byte_i`.
- `byte_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `we_o`  out  1  instruction memory write strobe.
- `waddr_o`  out  MEM_INSN_ADDR  write address.
- `wdata_o`  out  LEN_INSN  write data.
- `busy_o`  out  1  load in progress.
- `run_o`  out  1  image loaded; held high until reset. Feeds fetcher `valid_i`.
- `err_o`  out  1  checksum mismatch; sticky until reset.

## Operation
- States: IDLE, DATA, CHK (only when the macro is enabled), DONE.
- A byte is accepted on any edge where `byte_valid_i & byte_ready_o`.
- `byte_ready_o` is 1 only in DATA and CHK.
- IDLE, on `start_i`:
  - Latch `count_i`, saturated to 2**MEM_INSN_ADDR.
  - Clear the address counter and the byte index.
  - If the latched count is 0, go to DONE; otherwise go to DATA.
- DATA:
  - Accepted bytes fill the word starting at bits [7:0], then upward.
  - On the last byte of a word (index LEN_INSN/8-1), write that word at the current address, increment the address, and reset the byte index.
  - After the word at address count-1 is written, go to CHK, or to DONE when the macro is disabled.
- DONE: terminal state. `run_o` = ~`err_o`. Only `rst` leaves DONE.
- `start_i` in any state other than IDLE is ignored.
- Bytes offered outside DATA/CHK are not accepted. They remain pending at the source.
- Address arithmetic is MEM_INSN_ADDR bits wide. With a full-depth load the counter wraps to 0 after the final write. That is harmless because the count terminates the load.
- `rst` mid-load:
  - Return to IDLE next edge.
  - The partial word is discarded and no write is issued.
  - Words already written stay in memory.

## Timing
- Reset values: `byte_ready_o`=0, `we_o`=0, `waddr_o`=0, `wdata_o`=0, `busy_o`=0, `run_o`=0, `err_o`=0.
- `busy_o` is 1 from the edge after `start_i` until DONE is entered.
- Write latency: the final byte of a word is accepted at edge N; `we_o`, `waddr_o` and `wdata_o` are registered and valid in cycle N+1, for exactly one cycle.
- Throughput: one byte per cycle, sustained. There is no bubble between words.
- `run_o` rises one cycle after the last `we_o` pulse, or one cycle after CHK accepts the checksum byte. The write has therefore completed before the fetcher is released.
- Count 0: `run_o` rises 2 cycles after `start_i`, with no writes.

## Configuration
- `INSN_LOADER_CHECKSUM_EN`, when defined:
  - The loader keeps a running XOR of all data bytes.
  - After the last word, the CHK state accepts exactly one byte.
  - If that byte differs from the XOR, `err_o` is set to 1 and `run_o` stays 0.
- Without the macro:
  - There is no CHK state and no checksum register.
  - `err_o` is tied to 0.
  - The transition after the last word goes directly to DONE.

## Structure
- Shared definitions header (same one supplying LEN_INSN/MEM_INSN_ADDR): add the loader state encoding constants and LEN_INSN/8 as a bytes-per-instruction constant.
- One sub-module: `insn_byte_packer`, the byte-to-word shift/assemble with a byte index. It emits `word_valid` and `word` for one cycle. The top level holds the FSM, address counter, count and checksum.

## Test plan
- count=2, bytes 01 02 03 04 05 06 07 08 back-to-back -> `we_o` pulses at addr 0 data 0x04030201 and addr 1 data 0x08070605; `run_o`=1 one cycle after the second pulse.
- Same load with `byte_valid_i` toggling every other cycle -> identical writes; one write per 4 accepted bytes; `run_o` still rises.
- count=0 -> no `we_o`; `run_o`=1 two cycles after `start_i`; `busy_o` pulses for one cycle.
- `rst` asserted after 6 of 8 bytes -> second write never occurs; all outputs at reset values next cycle; a fresh start with count=1 writes addr 0.
- With `INSN_LOADER_CHECKSUM_EN` and the count=2 stream above:
  - Checksum byte 0x08 -> `run_o`=1, `err_o`=0.
  - Checksum byte 0x09 -> `err_o`=1, `run_o`=0.
- `start_i` pulsed mid-DATA with count=5 -> ignored; the load completes with the original count.

Source files
------------

// File: rtl/insn_loader_pkg.sv
// rtl/insn_loader_pkg.sv - shared widths, bytes-per-instruction and loader state encoding
package insn_loader_pkg;

    localparam int DEF_LEN_INSN      = 32;
    localparam int DEF_MEM_INSN_ADDR = 10;
    localparam int BYTES_PER_INSN    = DEF_LEN_INSN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/insn_byte_packer.sv
// rtl/insn_byte_packer.sv - assembles bytes little-endian into LEN_INSN-bit words, one-cycle word_valid
module insn_byte_packer #(
    parameter int LEN_INSN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                byte_en,
    input  logic [7:0]          byte_in,
    output logic                last_byte,
    output logic                word_valid,
    output logic [LEN_INSN-1:0] word
);

    localparam int BYTES = LEN_INSN / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDXW-1:0]     idx;
    logic [LEN_INSN-1:0] acc;
    logic [LEN_INSN-1:0] acc_next;

    assign last_byte = (idx == IDXW'(BYTES - 1));

    always_comb begin
        acc_next = acc;
        acc_next[int'(idx) * 8 +: 8] = byte_in;
    end

    // Stale upper bytes in acc are harmless: every byte lane is rewritten before a word is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_en) begin
                if (last_byte) begin
                    word       <= acc_next;
                    word_valid <= 1'b1;
                    idx        <= '0;
                end else begin
                    acc <= acc_next;
                    idx <= idx + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/insn_loader.sv
// rtl/insn_loader.sv - boot loader writing a byte stream into instruction memory; optional INSN_LOADER_CHECKSUM_EN
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int LEN_INSN      = DEF_LEN_INSN,
    parameter int MEM_INSN_ADDR = DEF_MEM_INSN_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [MEM_INSN_ADDR:0]   count_i,
    input  logic                     byte_valid_i,
    input  logic [7:0]               byte_i,
    output logic                     byte_ready_o,
    output logic                     we_o,
    output logic [MEM_INSN_ADDR-1:0] waddr_o,
    output logic [LEN_INSN-1:0]      wdata_o,
    output logic                     busy_o,
    output logic                     run_o,
    output logic                     err_o
);

    localparam logic [MEM_INSN_ADDR:0] MAX_COUNT = {1'b1, {MEM_INSN_ADDR{1'b0}}};

    loader_state_t              state;
    logic [MEM_INSN_ADDR-1:0]   addr;
    logic [MEM_INSN_ADDR:0]     remaining;
    logic [MEM_INSN_ADDR:0]     count_sat;
    logic                       accept;
    logic                       data_accept;
    logic                       last_byte;

    assign count_sat   = (count_i > MAX_COUNT) ? MAX_COUNT : count_i;
    assign accept      = byte_valid_i & byte_ready_o;
    assign data_accept = accept && (state == ST_DATA);

    insn_byte_packer #(
        .LEN_INSN (LEN_INSN)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_IDLE),
        .byte_en    (data_accept),
        .byte_in    (byte_i),
        .last_byte  (last_byte),
        .word_valid (we_o),
        .word       (wdata_o)
    );

`ifdef INSN_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            remaining    <= '0;
            waddr_o      <= '0;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            run_o        <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
            chk_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        addr      <= '0;
                        remaining <= count_sat;
                        busy_o    <= 1'b1;
`ifdef INSN_LOADER_CHECKSUM_EN
                        chk_q     <= '0;
`endif
                        if (count_sat == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state        <= ST_DATA;
                            byte_ready_o <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    busy_o <= 1'b1;
                    if (accept) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ byte_i;
`endif
                        // Packer registers the word on this same edge; waddr_o tracks it.
                        if (last_byte) begin
                            waddr_o   <= addr;
                            addr      <= addr + MEM_INSN_ADDR'(1);
                            remaining <= remaining - (MEM_INSN_ADDR+1)'(1);
                            if (remaining == (MEM_INSN_ADDR+1)'(1)) begin
`ifdef INSN_LOADER_CHECKSUM_EN
                                state <= ST_CHK;
`else
                                state        <= ST_DONE;
                                byte_ready_o <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef INSN_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    busy_o <= 1'b1;
                    if (accept) begin
                        err_q        <= (byte_i != chk_q);
                        state        <= ST_DONE;
                        byte_ready_o <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    busy_o <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
                    run_o  <= ~err_q;
`else
                    run_o  <= 1'b1;
`endif
                end
                default: begin
                    state        <= ST_IDLE;
                    byte_ready_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
